wr_ptr_ctrl_top_1: RTL and testbench
====================================

# wr_ptr_ctrl_top_1

Write-side pointer and flag controller for the asynchronous FIFO, in the `wr_clk` domain. It is directly downstream of the read-pointer synchronizer: it consumes the binary, `wr_clk`-domain read pointer and combines it with its own write pointer to produce the write address, the memory write enable, the fill level, and the `full` and `overflow` flags. Its binary write pointer drives the write-pointer synchronizer into the read domain.

## Interface
- `PTR_W`, default `` `a_length `` (3). Pointer width; one extra wrap bit above the address.
- `AF_THRESH`, default 1. Free-slot count at or below which `almost_full` asserts (`WR_ALMOST_FULL_EN` only).
- `wr_clk`  in  1  write clock; all state is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_req`  in  1  write request from the producer, synchronous to `wr_clk`.
- `b_rd_ptr_sync`  in  PTR_W  binary read pointer, already synchronized to `wr_clk`.
- `b_wr_ptr`  out  PTR_W  registered binary write pointer.
- `wr_addr`  out  PTR_W-1  memory write address, equal to `b_wr_ptr[PTR_W-2:0]`.
- `mem_wr_en`  out  1  memory write strobe; combinational, equal to `wr_req & ~full`.
- `full`  out  1  registered; no free slot.
- `wr_level`  out  PTR_W  registered occupancy as seen by the write side, range 0..DEPTH.
- `overflow`  out  1  sticky; a write was attempted while `full` was high.
- `almost_full`  out  1  registered; present only with `WR_ALMOST_FULL_EN`.

## Operation
- DEPTH = 2^(PTR_W-1). All pointer arithmetic is modulo 2^PTR_W.
- A write is accepted when `wr_req & ~full`. On acceptance, `next_wr_ptr = b_wr_ptr + 1`; otherwise `next_wr_ptr = b_wr_ptr`.
- Every cycle, whether or not a write occurs:
  - `diff = next_wr_ptr - b_rd_ptr_sync` (PTR_W bits, modular).
  - `wr_level <= diff`.
  - `full <= (diff >= DEPTH)`.
- A `diff` greater than DEPTH can only come from a corrupt or stale synchronized pointer. It is treated as full, and `wr_level` shows the raw value.
- `overflow` is set on any cycle with `wr_req & full`. It stays set until reset. A rejected write changes no other state.
- Wrap-around: pointer 2^PTR_W-1 increments to 0. `wr_addr` wraps every DEPTH writes, and the wrap bit toggles at the same time.
- Reset values (asynchronous, immediate, no clock needed): `b_wr_ptr`=0, `wr_level`=0, `full`=0, `overflow`=0, `almost_full`=0. `mem_wr_en` follows `wr_req` once `full` is 0.
- System rule: the read side and the synchronizer share the same `reset_n`, so `b_rd_ptr_sync` is 0 whenever this block leaves reset.

## Timing
- `mem_wr_en` is combinational. Write data is captured by memory at the same rising edge that advances `b_wr_ptr`.
- `b_wr_ptr`, `wr_level` and `full` update at the edge that accepts a write, and are visible one cycle later.
- The DEPTH-th outstanding write raises `full` at its own acceptance edge, so no extra write can slip through.
- Read-side release: a change on `b_rd_ptr_sync` is reflected in `wr_level` and `full` at the next edge.
- Full is pessimistic: if `b_rd_ptr_sync` advances on the same edge that accepts the filling write, `full` is high for one cycle and then clears.

## Configuration
- Macro `WR_ALMOST_FULL_EN`.
- Defined:
  - the `almost_full` port and register exist;
  - `almost_full <= (diff >= DEPTH - AF_THRESH)`;
  - reset value is 0.
- Undefined: the port, the register and `AF_THRESH` usage are removed. All other behaviour is identical.

## Structure
- `para.h` (shared header) holds `` `a_length ``, the derived DEPTH, the address width, and the default `AF_THRESH`. The read-side controller uses the same header.
- One sub-module, `ptr_diff_top_1`: a combinational modular subtraction of two PTR_W-bit pointers. It is reused later by the read-side empty logic.

## Test plan
All scenarios use PTR_W=3, DEPTH=4.
1. Fill: after reset, `b_rd_ptr_sync`=0, `wr_req` high for 5 cycles. Expect:
   - `wr_addr` 0,1,2,3;
   - `wr_level` 1..4;
   - `full`=1 after the 4th edge;
   - `mem_wr_en`=0 and `overflow`=1 on the 5th request;
   - `b_wr_ptr` stays 4.
2. Release: from full, step `b_rd_ptr_sync` 0→1. Expect `full`=0 and `wr_level`=3 one cycle later. The next write is accepted and `b_wr_ptr` becomes 5.
3. Wrap: run `b_wr_ptr` 7→0 with `b_rd_ptr_sync`=6. Expect `wr_addr` 3→0 and `wr_level`=2.
4. Simultaneous: at level 3, `b_rd_ptr_sync` increments on the same edge a write is accepted. Expect `full`=1 and `wr_level`=4 for one cycle, then `full`=0 and `wr_level`=3.
5. Mid-burst reset: drop `reset_n` between clock edges at level 3. Expect all registered outputs 0 immediately. After release, a write to `wr_addr` 0 is accepted.
6. Almost-full (`WR_ALMOST_FULL_EN`, `AF_THRESH`=1): `almost_full` rises when `wr_level` reaches 3 and falls when it returns to 2. Without the macro, the netlist has no `almost_full` port.

Source files
------------

// File: rtl/wr_ptr_ctrl_top_1_pkg.sv
// Shared FIFO sizing for the write- and read-side pointer controllers.
// Provides `A_LENGTH plus derived depth/address width; WR_ALMOST_FULL_EN users take AF_THRESH_DEF.
`ifndef A_LENGTH
`define A_LENGTH 3
`endif

package wr_ptr_ctrl_top_1_pkg;

    localparam int A_LENGTH      = `A_LENGTH;
    localparam int ADDR_W        = A_LENGTH - 1;
    localparam int DEPTH         = 1 << ADDR_W;
    localparam int AF_THRESH_DEF = 1;

    // One wrap bit sits above the address, so a PTR_W pointer spans 2^(PTR_W-1) slots.
    function automatic int depth_of(input int ptr_w);
        return 1 << (ptr_w - 1);
    endfunction

endpackage

// File: rtl/wr_ptr_ctrl_top_1_ptr_diff.sv
// Modular subtraction of two PTR_W-bit FIFO pointers (a - b mod 2^PTR_W).
// Shared by the write-side full logic and the read-side empty logic.
module ptr_diff_top_1 #(
    parameter int PTR_W = 3
) (
    input  logic [PTR_W-1:0] a,
    input  logic [PTR_W-1:0] b,
    output logic [PTR_W-1:0] diff
);

    assign diff = a - b;

endmodule

// File: rtl/wr_ptr_ctrl_top_1.sv
// Write-side pointer, address, level and full/overflow flags for the async FIFO (wr_clk domain).
// Optional almost_full output and AF_THRESH parameter exist only when WR_ALMOST_FULL_EN is defined.
module wr_ptr_ctrl_top_1
    import wr_ptr_ctrl_top_1_pkg::*;
#(
    parameter int PTR_W = A_LENGTH
`ifdef WR_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH = AF_THRESH_DEF
`endif
) (
    input  logic             wr_clk,
    input  logic             reset_n,
    input  logic             wr_req,
    input  logic [PTR_W-1:0] b_rd_ptr_sync,
    output logic [PTR_W-1:0] b_wr_ptr,
    output logic [PTR_W-2:0] wr_addr,
    output logic             mem_wr_en,
    output logic             full,
    output logic [PTR_W-1:0] wr_level,
    output logic             overflow
`ifdef WR_ALMOST_FULL_EN
    ,
    output logic             almost_full
`endif
);

    localparam int               DEPTH_L = depth_of(PTR_W);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH_L);

    logic [PTR_W-1:0] next_wr_ptr;
    logic [PTR_W-1:0] diff;

    assign mem_wr_en   = wr_req & ~full;
    assign wr_addr     = b_wr_ptr[PTR_W-2:0];
    assign next_wr_ptr = mem_wr_en ? b_wr_ptr + PTR_W'(1) : b_wr_ptr;

    // Level is computed from the post-write pointer so the filling write raises full at its own edge.
    ptr_diff_top_1 #(
        .PTR_W (PTR_W)
    ) u_ptr_diff (
        .a    (next_wr_ptr),
        .b    (b_rd_ptr_sync),
        .diff (diff)
    );

    // A diff above DEPTH means a stale/corrupt read pointer; >= keeps it treated as full.
    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            b_wr_ptr <= '0;
            wr_level <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            b_wr_ptr <= next_wr_ptr;
            wr_level <= diff;
            full     <= (diff >= DEPTH_P);
            overflow <= overflow | (wr_req & full);
        end
    end

`ifdef WR_ALMOST_FULL_EN
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH_L - AF_THRESH);

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (diff >= AF_LEVEL);
        end
    end
`endif

endmodule

// File: tb/tb_wr_ptr_ctrl_top_1.sv
// Self-checking bench for wr_ptr_ctrl_top_1 (PTR_W=3, DEPTH=4); define WR_ALMOST_FULL_EN to also cover almost_full.
// Reference model counts writes/reads as unbounded integers and derives level/full from their difference.
module tb_wr_ptr_ctrl_top_1;

    logic       wr_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_req = 1'b0;
    logic [2:0] b_rd_ptr_sync = 3'd0;
    logic [2:0] b_wr_ptr;
    logic [1:0] wr_addr;
    logic       mem_wr_en;
    logic       full;
    logic [2:0] wr_level;
    logic       overflow;
`ifdef WR_ALMOST_FULL_EN
    logic       almost_full;
`endif

    wr_ptr_ctrl_top_1 #(
        .PTR_W (3)
    ) dut (
        .wr_clk        (wr_clk),
        .reset_n       (reset_n),
        .wr_req        (wr_req),
        .b_rd_ptr_sync (b_rd_ptr_sync),
        .b_wr_ptr      (b_wr_ptr),
        .wr_addr       (wr_addr),
        .mem_wr_en     (mem_wr_en),
        .full          (full),
        .wr_level      (wr_level),
        .overflow      (overflow)
`ifdef WR_ALMOST_FULL_EN
        ,
        .almost_full   (almost_full)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_wr   = 0;
    int m_rd   = 0;
    int m_level = 0;
    bit m_full = 0;
    bit m_ovf  = 0;
    bit m_af   = 0;

    // Values observed just before the edge (combinational outputs)
    logic       obs_mem_wr_en;
    logic [1:0] obs_addr;
    bit         exp_mem_wr_en;
    logic [1:0] exp_addr;

    // Drive one cycle: set inputs at negedge, capture comb outputs, step model at posedge.
    task automatic cycle(input bit req, input int rd);
        bit full_before;
        @(negedge wr_clk);
        wr_req        = req;
        m_rd          = rd;
        b_rd_ptr_sync = 3'(rd % 8);
        #1;
        obs_mem_wr_en = mem_wr_en;
        obs_addr      = wr_addr;
        exp_mem_wr_en = req && !m_full;
        exp_addr      = 2'(m_wr % 4);
        @(posedge wr_clk);
        full_before = m_full;
        if (req && !full_before) m_wr++;
        if (req && full_before) m_ovf = 1;
        m_level = ((m_wr - rd) % 8 + 8) % 8;
        m_full  = (m_level >= 4);
        m_af    = (m_level >= 3);
        #1;
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_level = 0; m_full = 0; m_ovf = 0; m_af = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wr_req = 1'b0;
        b_rd_ptr_sync = 3'd0;
        model_reset();
        #12;
        n_checks++; if (b_wr_ptr !== 3'd0) $display("[TB] FAIL reset_ptr got %0d want 0", b_wr_ptr); else n_pass++;
        n_checks++; if (wr_level !== 3'd0) $display("[TB] FAIL reset_level got %0d want 0", wr_level); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", overflow); else n_pass++;
`ifdef WR_ALMOST_FULL_EN
        n_checks++; if (almost_full !== 1'b0) $display("[TB] FAIL reset_af got %b want 0", almost_full); else n_pass++;
`endif
        @(negedge wr_clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 0);
            if (i < 4) begin
                n_checks++; if (obs_addr !== 2'(i)) $display("[TB] FAIL fill_addr cyc%0d got %0d want %0d", i, obs_addr, i); else n_pass++;
            end
            n_checks++; if (obs_mem_wr_en !== (i < 4)) $display("[TB] FAIL fill_wen cyc%0d got %b want %b", i, obs_mem_wr_en, (i < 4)); else n_pass++;
            n_checks++; if (wr_level !== 3'((i < 4) ? i + 1 : 4)) $display("[TB] FAIL fill_level cyc%0d got %0d want %0d", i, wr_level, (i < 4) ? i + 1 : 4); else n_pass++;
            n_checks++; if (full !== (i >= 3)) $display("[TB] FAIL fill_full cyc%0d got %b want %b", i, full, (i >= 3)); else n_pass++;
            n_checks++; if (overflow !== (i == 4)) $display("[TB] FAIL fill_ovf cyc%0d got %b want %b", i, overflow, (i == 4)); else n_pass++;
`ifdef WR_ALMOST_FULL_EN
            n_checks++; if (almost_full !== (i >= 2)) $display("[TB] FAIL fill_af cyc%0d got %b want %b", i, almost_full, (i >= 2)); else n_pass++;
`endif
        end
        n_checks++; if (b_wr_ptr !== 3'd4) $display("[TB] FAIL fill_ptr got %0d want 4", b_wr_ptr); else n_pass++;
    endtask

    task automatic test_release();
        cycle(1'b0, 1);
        n_checks++; if (full !== 1'b0) $display("[TB] FAIL release_full got %b want 0", full); else n_pass++;
        n_checks++; if (wr_level !== 3'd3) $display("[TB] FAIL release_level got %0d want 3", wr_level); else n_pass++;
`ifdef WR_ALMOST_FULL_EN
        n_checks++; if (almost_full !== 1'b1) $display("[TB] FAIL release_af got %b want 1", almost_full); else n_pass++;
`endif
        cycle(1'b1, 1);
        n_checks++; if (obs_mem_wr_en !== 1'b1) $display("[TB] FAIL release_wen got %b want 1", obs_mem_wr_en); else n_pass++;
        n_checks++; if (b_wr_ptr !== 3'd5) $display("[TB] FAIL release_ptr got %0d want 5", b_wr_ptr); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("[TB] FAIL release_ovf_sticky got %b want 1", overflow); else n_pass++;
    endtask

    task automatic test_wrap();
        cycle(1'b0, 5);
        cycle(1'b1, 5);
        cycle(1'b1, 5);
        n_checks++; if (b_wr_ptr !== 3'd7) $display("[TB] FAIL wrap_pre_ptr got %0d want 7", b_wr_ptr); else n_pass++;
        cycle(1'b1, 6);
        n_checks++; if (obs_addr !== 2'd3) $display("[TB] FAIL wrap_addr_before got %0d want 3", obs_addr); else n_pass++;
        n_checks++; if (b_wr_ptr !== 3'd0) $display("[TB] FAIL wrap_ptr got %0d want 0", b_wr_ptr); else n_pass++;
        n_checks++; if (wr_addr !== 2'd0) $display("[TB] FAIL wrap_addr_after got %0d want 0", wr_addr); else n_pass++;
        n_checks++; if (wr_level !== 3'd2) $display("[TB] FAIL wrap_level got %0d want 2", wr_level); else n_pass++;
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 6);
        n_checks++; if (wr_level !== 3'd3) $display("[TB] FAIL simul_pre_level got %0d want 3", wr_level); else n_pass++;
        cycle(1'b1, 6);
        n_checks++; if (full !== 1'b1) $display("[TB] FAIL simul_full got %b want 1", full); else n_pass++;
        n_checks++; if (wr_level !== 3'd4) $display("[TB] FAIL simul_level got %0d want 4", wr_level); else n_pass++;
        cycle(1'b0, 7);
        n_checks++; if (full !== 1'b0) $display("[TB] FAIL simul_clear_full got %b want 0", full); else n_pass++;
        n_checks++; if (wr_level !== 3'd3) $display("[TB] FAIL simul_clear_level got %0d want 3", wr_level); else n_pass++;
`ifdef WR_ALMOST_FULL_EN
        cycle(1'b0, 0 + 8);
        n_checks++; if (almost_full !== 1'b0) $display("[TB] FAIL af_fall got %b want 0 (level %0d)", almost_full, wr_level); else n_pass++;
        cycle(1'b0, 7);
        n_checks++; if (almost_full !== 1'b1) $display("[TB] FAIL af_rise got %b want 1", almost_full); else n_pass++;
`endif
    endtask

    task automatic test_mid_reset();
        @(negedge wr_clk);
        wr_req = 1'b0;
        #2;
        reset_n = 1'b0;
        b_rd_ptr_sync = 3'd0;
        model_reset();
        #1;
        n_checks++; if (b_wr_ptr !== 3'd0) $display("[TB] FAIL midrst_ptr got %0d want 0", b_wr_ptr); else n_pass++;
        n_checks++; if (wr_level !== 3'd0) $display("[TB] FAIL midrst_level got %0d want 0", wr_level); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("[TB] FAIL midrst_ovf got %b want 0", overflow); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("[TB] FAIL midrst_full got %b want 0", full); else n_pass++;
        @(negedge wr_clk);
        reset_n = 1'b1;
        cycle(1'b1, 0);
        n_checks++; if (obs_addr !== 2'd0) $display("[TB] FAIL midrst_addr got %0d want 0", obs_addr); else n_pass++;
        n_checks++; if (obs_mem_wr_en !== 1'b1) $display("[TB] FAIL midrst_wen got %b want 1", obs_mem_wr_en); else n_pass++;
        n_checks++; if (b_wr_ptr !== 3'd1) $display("[TB] FAIL midrst_ptr_after got %0d want 1", b_wr_ptr); else n_pass++;
    endtask

    task automatic test_random();
        int rd;
        bit req;
        rd = m_rd;
        for (int i = 0; i < 300; i++) begin
            req = ($urandom_range(0, 99) < 60);
            if (rd < m_wr && $urandom_range(0, 99) < 45) rd++;
            cycle(req, rd);
            n_checks++; if (obs_mem_wr_en !== exp_mem_wr_en) $display("[TB] FAIL rand_wen cyc%0d got %b want %b", i, obs_mem_wr_en, exp_mem_wr_en); else n_pass++;
            n_checks++; if (obs_addr !== exp_addr) $display("[TB] FAIL rand_addr cyc%0d got %0d want %0d", i, obs_addr, exp_addr); else n_pass++;
            n_checks++; if (b_wr_ptr !== 3'(m_wr % 8)) $display("[TB] FAIL rand_ptr cyc%0d got %0d want %0d", i, b_wr_ptr, m_wr % 8); else n_pass++;
            n_checks++; if (wr_level !== 3'(m_level)) $display("[TB] FAIL rand_level cyc%0d got %0d want %0d", i, wr_level, m_level); else n_pass++;
            n_checks++; if (full !== m_full) $display("[TB] FAIL rand_full cyc%0d got %b want %b", i, full, m_full); else n_pass++;
            n_checks++; if (overflow !== m_ovf) $display("[TB] FAIL rand_ovf cyc%0d got %b want %b", i, overflow, m_ovf); else n_pass++;
`ifdef WR_ALMOST_FULL_EN
            n_checks++; if (almost_full !== m_af) $display("[TB] FAIL rand_af cyc%0d got %b want %b", i, almost_full, m_af); else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
